// File: rtl/rpn_eval_ctrl.sv
// rpn_eval_ctrl: postfix (RPN) expression sequencer.
// Fetches byte tokens from a shared byte memory, keeps a 16-bit sign-magnitude operand
// stack, hands add/sub/mul to an external ALU over a req/ack handshake and writes the
// final result back to memory as two bytes (high byte first), then pulses FINISH.
//
// Ports:
//   CLK, RST_N        clock (rising edge) and synchronous active-low reset
//   START             one-cycle start pulse, honoured only in IDLE
//   ADRS, R_WB, DATA  memory port; DATA is driven only while R_WB=0
//   FINISH            one-cycle completion pulse
//   ERR, OVF          sticky expression-error / magnitude-saturation flags
//   ALU_REQ/OP/A/B    ALU request, opcode (00 add, 01 sub, 10 mul) and operands
//   ALU_ACK, ALU_RES  ALU result strobe and 32-bit sign-magnitude result
module rpn_eval_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [9:0]  PROG_BASE = 10'h000,
    parameter logic [9:0]  RES_ADDR  = 10'h3FE
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    output logic [9:0]  ADRS,
    output logic        R_WB,
    inout  wire  [7:0]  DATA,
    output logic        FINISH,
    output logic        ERR,
    output logic        OVF,
    output logic        ALU_REQ,
    output logic [1:0]  ALU_OP,
    output logic [15:0] ALU_A,
    output logic [15:0] ALU_B,
    input  logic        ALU_ACK,
    input  logic [31:0] ALU_RES
);

    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StIssue, StWrHi, StWrLo, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      ptr_q, ptr_d;
    logic [SpW-1:0]  sp_q, sp_d;
    logic [7:0]      tok_q;
    logic [15:0]     stack_q [DEPTH];
    logic [15:0]     alu_a_q, alu_b_q;
    logic [1:0]      alu_op_q;
    logic            err_q, ovf_q;

    logic            tok_en, load_alu, push_en, advance;
    logic            set_err, set_ovf, clr_flags;
    logic [15:0]     push_val;
    logic [7:0]      wr_byte;

    logic [IdxW-1:0] top_idx, nxt_idx, wr_idx;
    logic            ptr_last;
    logic            res_sat;
    logic [14:0]     res_mag;
    logic [15:0]     res_word;

    assign top_idx  = IdxW'(sp_q - SpW'(1));
    assign nxt_idx  = IdxW'(sp_q - SpW'(2));
    assign wr_idx   = IdxW'(sp_q);
    // The token region ends one below the result bytes; never fetch there.
    assign ptr_last = (ptr_q + 10'd1) == RES_ADDR;

    // Saturate the 31-bit ALU magnitude into 15 bits; a zero result is always +0.
    assign res_sat  = |ALU_RES[30:15];
    assign res_mag  = res_sat ? 15'h7FFF : ALU_RES[14:0];
    assign res_word = {ALU_RES[31] & (res_mag != 15'd0), res_mag};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sp_d      = sp_q;
        tok_en    = 1'b0;
        load_alu  = 1'b0;
        push_en   = 1'b0;
        push_val  = 16'h0000;
        advance   = 1'b0;
        set_err   = 1'b0;
        set_ovf   = 1'b0;
        clr_flags = 1'b0;
        ADRS      = ptr_q;
        R_WB      = 1'b1;
        ALU_REQ   = 1'b0;
        FINISH    = 1'b0;
        wr_byte   = stack_q[0][7:0];

        unique case (state_q)
            StIdle: begin
                ADRS = PROG_BASE;
                if (START) begin
                    clr_flags = 1'b1;
                    ptr_d     = PROG_BASE;
                    sp_d      = '0;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                tok_en  = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                if (!tok_q[7]) begin
                    if (sp_q == SpW'(DEPTH)) begin
                        set_err = 1'b1;
                        state_d = StDone;
                    end else begin
                        push_en  = 1'b1;
                        push_val = {tok_q[6], 9'b0, tok_q[5:0]};
                        sp_d     = sp_q + SpW'(1);
                        advance  = 1'b1;
                    end
                end else if (tok_q == 8'h80 || tok_q == 8'h81 || tok_q == 8'h82) begin
                    if (sp_q < SpW'(2)) begin
                        set_err = 1'b1;
                        state_d = StDone;
                    end else begin
                        load_alu = 1'b1;
                        sp_d     = sp_q - SpW'(2);
                        state_d  = StIssue;
                    end
                end else if (tok_q == 8'hFF && sp_q == SpW'(1)) begin
                    state_d = StWrHi;
                end else begin
                    set_err = 1'b1;
                    state_d = StDone;
                end
            end
            StIssue: begin
                ALU_REQ = 1'b1;
                if (ALU_ACK) begin
                    push_en  = 1'b1;
                    push_val = res_word;
                    set_ovf  = res_sat;
                    sp_d     = sp_q + SpW'(1);
                    advance  = 1'b1;
                end
            end
            StWrHi: begin
                ADRS    = RES_ADDR;
                R_WB    = 1'b0;
                wr_byte = stack_q[0][15:8];
                state_d = StWrLo;
            end
            StWrLo: begin
                ADRS    = RES_ADDR + 10'd1;
                R_WB    = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                FINISH  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (ptr_last) begin
                set_err = 1'b1;
                state_d = StDone;
            end else begin
                ptr_d   = ptr_q + 10'd1;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            sp_q     <= '0;
            tok_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sp_q    <= sp_d;
            if (tok_en) tok_q <= DATA;
            if (load_alu) begin
                alu_a_q  <= stack_q[nxt_idx];
                alu_b_q  <= stack_q[top_idx];
                alu_op_q <= tok_q[1:0];
            end
            if (clr_flags) begin
                err_q <= 1'b0;
                ovf_q <= 1'b0;
            end
            if (set_err) err_q <= 1'b1;
            if (set_ovf) ovf_q <= 1'b1;
        end
    end

    // Stack storage needs no reset; sp alone defines which entries are live.
    always_ff @(posedge CLK) begin
        if (RST_N && push_en) stack_q[wr_idx] <= push_val;
    end

    assign DATA   = R_WB ? 8'hzz : wr_byte;
    assign ERR    = err_q;
    assign OVF    = ovf_q;
    assign ALU_A  = alu_a_q;
    assign ALU_B  = alu_b_q;
    assign ALU_OP = alu_op_q;

endmodule
